auto_threshold_ctrl: RTL and testbench
======================================

Name: auto_threshold_ctrl

Overview:
Frame-rate controller that sets the THRESHOLD input of the RGB-to-binary stage. It measures mean gray level over each frame and computes the next frame's threshold as mean + offset, clamped to 0..255. It also reports the white-pixel area per frame. It sits beside the binarizer in the D8M video path, fed by the gray/binary outputs and a frame-start strobe from the VGA timing logic.

Parameters:
CNT_W, 22, width of per-frame pixel counters (covers up to 1920x1080)
OFFSET, 0, signed 9-bit value added to the frame mean
INIT_TH, 128, THRESHOLD value after reset

Ports:
CLK  in  1  pixel clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
FRAME_START  in  1  one-cycle pulse at the start of each frame
PIXEL_VALID  in  1  high for active-video pixels
GRAY  in  8  gray level of the current pixel (low byte of VGA_GRAY)
BINARY_FLAG  in  1  binarizer decision for the current pixel
MANUAL_EN  in  1  1 = bypass auto mode and use MANUAL_TH
MANUAL_TH  in  8  manual threshold
THRESHOLD  out  8  threshold to the binarizer (registered)
TH_UPDATE  out  1  one-cycle pulse when THRESHOLD is loaded from auto computation
MEAN  out  8  last completed frame mean (registered)
WHITE_COUNT  out  CNT_W  BINARY_FLAG=1 pixel count of last completed frame
BUSY  out  1  high while in DIVIDE or UPDATE

Behaviour:
- Reset (asynchronous, any state): THRESHOLD=INIT_TH, MEAN=0, WHITE_COUNT=0, TH_UPDATE=0, BUSY=0. All accumulators cleared. State=IDLE.
- States: IDLE, ACCUM, DIVIDE, UPDATE.
- IDLE: waits for the first FRAME_START, then goes to ACCUM. Pixels before that strobe are discarded and no division is run.
- Accumulators: PIX_CNT (CNT_W bits), WHITE_CNT (CNT_W bits), SUM (CNT_W+8 bits).
  - Each edge with PIXEL_VALID=1: PIX_CNT+1, SUM+GRAY, WHITE_CNT+BINARY_FLAG.
  - Saturation: once PIX_CNT reaches 2^CNT_W-1, PIX_CNT, SUM and WHITE_CNT all hold for the rest of the frame.
- FRAME_START sampled in ACCUM:
  - Latch SUM/PIX_CNT into divider operands; WHITE_COUNT <= WHITE_CNT.
  - Accumulators restart. A valid pixel on the FRAME_START cycle belongs to the new frame: counters load 1/GRAY/flag rather than 0.
  - If PIX_CNT=0: stay in ACCUM; THRESHOLD, MEAN and TH_UPDATE are unchanged.
  - Otherwise go to DIVIDE.
- Accumulation continues in every non-IDLE state.
- DIVIDE: restoring divider, exactly 8 cycles, one quotient bit per cycle MSB first. Result is the floor of SUM/PIX_CNT, always <= 255. Then go to UPDATE.
- UPDATE (1 cycle):
  - MEAN <= quotient.
  - T = quotient + OFFSET in 10-bit signed arithmetic, clamped to [0,255].
  - If MANUAL_EN=0: THRESHOLD <= T and TH_UPDATE=1 for this one cycle.
  - Return to ACCUM.
- Latency: THRESHOLD/TH_UPDATE register on the 10th rising edge after the edge that sampled FRAME_START. BUSY is high for the 9 cycles preceding it.
- FRAME_START during DIVIDE/UPDATE:
  - Accumulators restart, as at any frame boundary.
  - The in-flight division completes and publishes normally.
  - The frame just ended is discarded and WHITE_COUNT is not updated.
- MANUAL_EN=1: THRESHOLD <= MANUAL_TH every edge and TH_UPDATE is held 0. MEAN and WHITE_COUNT still update. Clearing MANUAL_EN leaves THRESHOLD at the last manual value until the next UPDATE.
- Mid-operation reset aborts any division; the next FRAME_START is treated as the first.

Test Plan:
- Reset, FRAME_START, 16 pixels GRAY=100 with OFFSET=10, FRAME_START -> MEAN=100, THRESHOLD=110, TH_UPDATE pulses once on the 10th edge after the strobe.
- Frame of 2 pixels GRAY=10,11 with OFFSET=0 -> MEAN=10 (floor), THRESHOLD=10; 4 pixels of which 3 have BINARY_FLAG=1 -> WHITE_COUNT=3.
- Clamp: GRAY=250 with OFFSET=10 -> THRESHOLD=255; GRAY=5 with OFFSET=-20 -> THRESHOLD=0.
- Frame with no PIXEL_VALID -> no TH_UPDATE, BUSY stays 0, THRESHOLD keeps its prior value (128 after reset).
- MANUAL_EN=1, MANUAL_TH=42 across a frame boundary -> THRESHOLD=42 next edge, TH_UPDATE never asserted, MEAN still updated.
- Assert RESET_N=0 at the 4th DIVIDE cycle -> all outputs at reset values immediately; next FRAME_START produces no TH_UPDATE.

Source files
------------

// File: rtl/auto_threshold_ctrl.sv
// Purpose: per-frame mean-gray auto threshold for the binarizer, plus white-pixel area per frame.
// Latency: THRESHOLD/TH_UPDATE load on the 10th clk_i edge after the edge that samples frame_start_i.
// Backpressure: none; the pixel stream is consumed every cycle and cannot be stalled.
//
// Ports:
//   clk_i, rst_ni         pixel clock, asynchronous active-low reset
//   frame_start_i         one-cycle frame strobe from VGA timing
//   pixel_valid_i         active-video qualifier for gray_i/binary_flag_i
//   gray_i[7:0]           gray level of the current pixel
//   binary_flag_i         binarizer decision for the current pixel
//   manual_en_i           1 = threshold follows manual_th_i every cycle
//   manual_th_i[7:0]      manual threshold
//   threshold_o[7:0]      registered threshold to the binarizer
//   th_update_o           one-cycle pulse when threshold_o is loaded by the auto path
//   mean_o[7:0]           mean gray of the last completed frame
//   white_count_o         white-pixel count of the last completed frame
//   busy_o                high while the divider or update step is running
module auto_threshold_ctrl #(
  parameter int                 CNT_W   = 22,
  parameter logic signed [8:0]  OFFSET  = 9'sd0,
  parameter logic        [7:0]  INIT_TH = 8'd128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_start_i,
  input  logic             pixel_valid_i,
  input  logic [7:0]       gray_i,
  input  logic             binary_flag_i,
  input  logic             manual_en_i,
  input  logic [7:0]       manual_th_i,
  output logic [7:0]       threshold_o,
  output logic             th_update_o,
  output logic [7:0]       mean_o,
  output logic [CNT_W-1:0] white_count_o,
  output logic             busy_o
);

  localparam int                SW      = CNT_W + 8;
  localparam logic [CNT_W-1:0]  PIX_MAX = '1;
  localparam logic signed [9:0] OFF10   = 10'(OFFSET);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, UPDATE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, white_cnt_q, white_count_q;
  logic [SW-1:0]    sum_q, rem_q, dsr_q;
  logic [7:0]       quo_q, threshold_q, mean_q;
  logic [2:0]       step_q;
  logic             div_go_q, th_update_q;

  logic             frame_end;
  logic signed [9:0] t_raw;
  logic [7:0]       t_clamp;

  // Next state. A frame boundary seen in ACCUM latches the operands and sets
  // div_go_q; the divider then starts on the following cycle. Strobes that
  // arrive while a division is pending or running discard the ended frame.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE:   if (frame_start_i) state_d = ACCUM;
      ACCUM: begin
        if (div_go_q) state_d = DIVIDE;
        else          frame_end = frame_start_i;
      end
      DIVIDE: if (step_q == 3'd7) state_d = UPDATE;
      UPDATE: state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // quotient + offset, clamped to 0..255 (range fits 10-bit signed).
  always_comb begin
    t_raw = $signed({2'b00, quo_q}) + OFF10;
    if (t_raw[9])      t_clamp = 8'd0;
    else if (t_raw[8]) t_clamp = 8'd255;
    else               t_clamp = t_raw[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      white_cnt_q   <= '0;
      sum_q         <= '0;
      white_count_q <= '0;
      rem_q         <= '0;
      dsr_q         <= '0;
      quo_q         <= '0;
      step_q        <= '0;
      div_go_q      <= 1'b0;
      threshold_q   <= INIT_TH;
      mean_q        <= '0;
      th_update_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Accumulators: a valid pixel on the strobe cycle opens the new frame.
      if (frame_start_i) begin
        pix_cnt_q   <= pixel_valid_i ? CNT_W'(1) : '0;
        sum_q       <= pixel_valid_i ? SW'(gray_i) : '0;
        white_cnt_q <= pixel_valid_i ? CNT_W'(binary_flag_i) : '0;
      end else if (state_q != IDLE && pixel_valid_i && pix_cnt_q != PIX_MAX) begin
        pix_cnt_q   <= pix_cnt_q + CNT_W'(1);
        sum_q       <= sum_q + SW'(gray_i);
        white_cnt_q <= white_cnt_q + CNT_W'(binary_flag_i);
      end

      // Frame close: divisor pre-shifted by 7 so the first step yields quotient bit 7.
      div_go_q <= 1'b0;
      if (frame_end) begin
        white_count_q <= white_cnt_q;
        if (pix_cnt_q != '0) begin
          rem_q    <= sum_q;
          dsr_q    <= {1'b0, pix_cnt_q, 7'd0};
          div_go_q <= 1'b1;
        end
      end

      // Restoring division, one quotient bit per cycle, MSB first.
      if (state_q == DIVIDE) begin
        if (rem_q >= dsr_q) begin
          rem_q <= rem_q - dsr_q;
          quo_q <= {quo_q[6:0], 1'b1};
        end else begin
          quo_q <= {quo_q[6:0], 1'b0};
        end
        dsr_q  <= dsr_q >> 1;
        step_q <= step_q + 3'd1;
      end else begin
        step_q <= '0;
      end

      if (state_q == UPDATE) mean_q <= quo_q;

      th_update_q <= (state_q == UPDATE) && !manual_en_i;
      if (manual_en_i)             threshold_q <= manual_th_i;
      else if (state_q == UPDATE)  threshold_q <= t_clamp;
    end
  end

  assign threshold_o   = threshold_q;
  assign th_update_o   = th_update_q;
  assign mean_o        = mean_q;
  assign white_count_o = white_count_q;
  assign busy_o        = (state_q == DIVIDE) || (state_q == UPDATE);

endmodule

// File: tb/tb_auto_threshold_ctrl.sv
// Bench for auto_threshold_ctrl: three instances (OFFSET = +10, 0, -20) share one
// directed stimulus stream; a frame-level model predicts every output each cycle,
// and literal expectations pin the model at key points.
module tb_auto_threshold_ctrl;

  localparam int CW = 22;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fs = 1'b0, pv = 1'b0, bf = 1'b0, men = 1'b0;
  logic [7:0] gray = 8'd0, mth = 8'd0;

  logic [7:0]    th_o    [3];
  logic [7:0]    mean_o  [3];
  logic          upd_o   [3];
  logic          busy_o  [3];
  logic [CW-1:0] white_o [3];

  always #5 clk = ~clk;

  auto_threshold_ctrl #(.CNT_W(CW), .OFFSET(9'sd10), .INIT_TH(8'd128)) u_p10 (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .pixel_valid_i(pv), .gray_i(gray),
    .binary_flag_i(bf), .manual_en_i(men), .manual_th_i(mth), .threshold_o(th_o[0]),
    .th_update_o(upd_o[0]), .mean_o(mean_o[0]), .white_count_o(white_o[0]), .busy_o(busy_o[0]));

  auto_threshold_ctrl #(.CNT_W(CW), .OFFSET(9'sd0), .INIT_TH(8'd128)) u_z (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .pixel_valid_i(pv), .gray_i(gray),
    .binary_flag_i(bf), .manual_en_i(men), .manual_th_i(mth), .threshold_o(th_o[1]),
    .th_update_o(upd_o[1]), .mean_o(mean_o[1]), .white_count_o(white_o[1]), .busy_o(busy_o[1]));

  auto_threshold_ctrl #(.CNT_W(CW), .OFFSET(-9'sd20), .INIT_TH(8'd128)) u_m20 (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .pixel_valid_i(pv), .gray_i(gray),
    .binary_flag_i(bf), .manual_en_i(men), .manual_th_i(mth), .threshold_o(th_o[2]),
    .th_update_o(upd_o[2]), .mean_o(mean_o[2]), .white_count_o(white_o[2]), .busy_o(busy_o[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp255(input int x);
    if (x < 0)   return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  // ---------------- frame-level model ----------------
  // A closed frame with pixels publishes its mean 10 edges after its strobe;
  // the divider is visible as busy for the 9 edges before that. A strobe
  // while a publication is outstanding throws the ended frame away.
  int     offs [3] = '{10, 0, -20};
  int     e = 0;
  bit     m_started = 1'b0;
  int     m_n = 0, m_white = 0;
  longint m_sum = 0;
  bit     p_vld = 1'b0;
  int     p_at = 0, p_val = 0;
  int     x_th [3] = '{128, 128, 128};
  int     x_mean = 0, x_white = 0;
  bit     x_upd = 1'b0, x_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0; m_n = 0; m_white = 0; m_sum = 0;
      p_vld = 1'b0; p_at = 0; p_val = 0;
      for (int i = 0; i < 3; i++) x_th[i] = 128;
      x_mean = 0; x_white = 0; x_upd = 1'b0; x_busy = 1'b0;
    end else begin
      e++;
      x_upd = 1'b0;
      if (fs) begin
        if (m_started && !p_vld) begin
          x_white = m_white;
          if (m_n > 0) begin
            p_vld = 1'b1;
            p_at  = e + 10;
            p_val = int'(m_sum / longint'(m_n));
          end
        end
        m_started = 1'b1;
        m_n     = pv ? 1 : 0;
        m_sum   = pv ? longint'(gray) : 0;
        m_white = (pv && bf) ? 1 : 0;
      end else if (m_started && pv && m_n < (1 << CW) - 1) begin
        m_n     = m_n + 1;
        m_sum   = m_sum + longint'(gray);
        m_white = m_white + (bf ? 1 : 0);
      end
      if (p_vld && e == p_at) begin
        p_vld  = 1'b0;
        x_mean = p_val;
        if (!men) begin
          x_upd = 1'b1;
          for (int i = 0; i < 3; i++) x_th[i] = clamp255(p_val + offs[i]);
        end
      end
      if (men) for (int i = 0; i < 3; i++) x_th[i] = int'(mth);
      x_busy = p_vld && (e >= p_at - 9);
    end
  end

  // Compare every output of every instance on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("threshold[%0d]", i), int'(th_o[i]), x_th[i]);
      chk($sformatf("mean[%0d]", i), int'(mean_o[i]), x_mean);
      chk($sformatf("white_count[%0d]", i), int'(white_o[i]), x_white);
      chk($sformatf("th_update[%0d]", i), int'(upd_o[i]), int'(x_upd));
      chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(x_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pix(input int g, input bit f);
    fs = 1'b0; pv = 1'b1; gray = 8'(g); bf = f;
    @(posedge clk); #1;
    pv = 1'b0; bf = 1'b0;
  endtask

  task automatic strobe();
    fs = 1'b1; pv = 1'b0; bf = 1'b0;
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  task automatic idle(input int n);
    fs = 1'b0; pv = 1'b0; bf = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Watches 12 edges after a strobe on the +10 instance.
  task automatic wait_pub(output int upd_cnt, output int upd_edge, output int busy_cnt);
    upd_cnt = 0; upd_edge = 0; busy_cnt = 0;
    fs = 1'b0; pv = 1'b0; bf = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (upd_o[0])  begin upd_cnt++; upd_edge = k; end
      if (busy_o[0]) busy_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int uc, ue, bc;

  initial begin
    do_reset();
    idle(2);
    chk("reset threshold", int'(th_o[1]), 128);
    chk("reset mean", int'(mean_o[1]), 0);
    chk("reset busy", int'(busy_o[1]), 0);

    // 16 pixels of 100.
    strobe();
    for (int i = 0; i < 16; i++) pix(100, 1'b0);
    idle(2);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit mean 100", int'(mean_o[0]), 100);
    chk("lit th 100+10", int'(th_o[0]), 110);
    chk("lit upd edge", ue, 10);
    chk("lit upd count", uc, 1);
    chk("lit busy cycles", bc, 9);

    // Floor of 21/2.
    pix(10, 1'b0); pix(11, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit mean floor", int'(mean_o[1]), 10);
    chk("lit th floor", int'(th_o[1]), 10);

    // White area.
    pix(200, 1'b1); pix(200, 1'b1); pix(200, 1'b0); pix(200, 1'b1);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit white 3", int'(white_o[1]), 3);

    // Clamp high / low.
    for (int i = 0; i < 3; i++) pix(250, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit clamp 255", int'(th_o[0]), 255);
    for (int i = 0; i < 3; i++) pix(5, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit clamp 0", int'(th_o[2]), 0);

    // Strobe during divide: frame of 200s is dropped.
    pix(30, 1'b0); pix(30, 1'b0);
    strobe();
    pix(200, 1'b1); pix(200, 1'b1);
    strobe();
    pix(40, 1'b0); pix(40, 1'b0);
    idle(10);
    chk("lit mean in-flight", int'(mean_o[1]), 30);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit mean after drop", int'(mean_o[1]), 40);

    // Manual override.
    men = 1'b1; mth = 8'd42;
    idle(1);
    chk("lit manual next edge", int'(th_o[0]), 42);
    for (int i = 0; i < 4; i++) pix(60, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit manual no upd", uc, 0);
    chk("lit manual mean", int'(mean_o[1]), 60);
    chk("lit manual th", int'(th_o[2]), 42);
    men = 1'b0;
    idle(1);
    chk("lit manual held", int'(th_o[1]), 42);
    pix(70, 1'b0); pix(70, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit auto resumes", int'(th_o[1]), 70);

    // Empty frame after reset.
    do_reset();
    strobe();
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit empty no upd", uc, 0);
    chk("lit empty no busy", bc, 0);
    chk("lit empty th", int'(th_o[1]), 128);

    // Reset in the 4th divide cycle.
    for (int i = 0; i < 4; i++) pix(90, 1'b1);
    strobe();
    repeat (4) begin @(posedge clk); #1; end
    chk("lit busy before abort", int'(busy_o[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("lit abort th", int'(th_o[0]), 128);
    chk("lit abort mean", int'(mean_o[0]), 0);
    chk("lit abort white", int'(white_o[0]), 0);
    chk("lit abort busy", int'(busy_o[0]), 0);
    chk("lit abort upd", int'(upd_o[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pix(90, 1'b0); pix(90, 1'b0);
    strobe();
    wait_pub(uc, ue, bc);
    chk("lit first strobe no upd", uc, 0);
    chk("lit first strobe no busy", bc, 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
